// File: rtl/npu_feature_loader.sv
// Host-to-NPU feature loader: packs 32-bit register halves into 64-bit words,
// buffers them, and streams them out on a valid/ready handshake.
// Optional looping playback is compiled in with NPU_LOADER_REPEAT_EN.
module npu_feature_loader #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_wr,
  input  logic [1:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic [31:0]           status,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [31:0]           staged_lo_q, staged_lo_d;
  logic                  overflow_q, overflow_d;
  logic                  write_err_q, write_err_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] buf_mem [DEPTH];

  logic lo_wr, hi_wr, ctrl_wr, push, load_out, last_beat;

`ifdef NPU_LOADER_REPEAT_EN
  logic repeat_q, repeat_d;
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^reg_wdata[31:4];
`else
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^{reg_wdata[31:4], reg_wdata[2]};
`endif

  assign lo_wr     = reg_wr && (reg_addr == 2'd0);
  assign hi_wr     = reg_wr && (reg_addr == 2'd1);
  assign ctrl_wr   = reg_wr && (reg_addr == 2'd2);
  assign last_beat = ({1'b0, rd_ptr_q} == (count_q - ONE_C));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    staged_lo_d = staged_lo_q;
    overflow_d  = overflow_q;
    write_err_d = write_err_q;
    data_out_d  = data_out_q;
    push        = 1'b0;
    load_out    = 1'b0;
`ifdef NPU_LOADER_REPEAT_EN
    repeat_d    = repeat_q;
`endif

    // Data writes are only accepted while idle; otherwise they are flagged.
    if (lo_wr || hi_wr) begin
      if (state_q != IDLE) begin
        write_err_d = 1'b1;
      end else if (lo_wr) begin
        staged_lo_d = reg_wdata;
      end else if (count_q == DEPTH_C) begin
        overflow_d = 1'b1;
      end else begin
        push     = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + ONE_C;
      end
    end

    case (state_q)
      IDLE: begin
        if (ctrl_wr && reg_wdata[0] && (count_q != '0)) begin
          rd_ptr_d = '0;
          load_out = 1'b1;
          state_d  = STREAM;
`ifdef NPU_LOADER_REPEAT_EN
          repeat_d = reg_wdata[2];
`endif
        end
      end
      STREAM: begin
        if (data_ready) begin
          if (last_beat) begin
`ifdef NPU_LOADER_REPEAT_EN
            if (repeat_q) begin
              rd_ptr_d = '0;
              load_out = 1'b1;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            load_out = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Clear wins over start and over any in-flight stream.
    if (ctrl_wr && reg_wdata[1]) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = IDLE;
      load_out = 1'b0;
`ifdef NPU_LOADER_REPEAT_EN
      repeat_d = 1'b0;
`endif
    end

    if (ctrl_wr && reg_wdata[3]) begin
      overflow_d  = 1'b0;
      write_err_d = 1'b0;
    end

    if (load_out) begin
      data_out_d = buf_mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      staged_lo_q <= '0;
      overflow_q  <= 1'b0;
      write_err_q <= 1'b0;
      data_out_q  <= '0;
`ifdef NPU_LOADER_REPEAT_EN
      repeat_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      staged_lo_q <= staged_lo_d;
      overflow_q  <= overflow_d;
      write_err_q <= write_err_d;
      data_out_q  <= data_out_d;
`ifdef NPU_LOADER_REPEAT_EN
      repeat_q    <= repeat_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr_q] <= {reg_wdata, staged_lo_q};
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = (state_q == STREAM);
  assign busy       = (state_q == STREAM);
  assign done       = (state_q == DONE);
  assign status     = {20'b0, overflow_q, write_err_q, state_q, 8'(count_q)};

endmodule

// File: tb/tb_npu_feature_loader.sv
// Directed self-checking bench for npu_feature_loader.
// Define NPU_LOADER_REPEAT_EN to also exercise the looping playback mode.
module tb_npu_feature_loader;

   logic        clk;
   logic        reset;
   logic        reg_wr;
   logic [1:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] status;
   logic [63:0] data_out;
   logic        data_valid;
   logic        data_ready;
   logic        busy;
   logic        done;

   int compareCount;
   int mismatchCount;
   int handshakeCount;

   npu_feature_loader dut (
      .clk        (clk),
      .reset      (reset),
      .reg_wr     (reg_wr),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .status     (status),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .done       (done)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent tally of accepted beats, used to confirm handshake counts
   initial handshakeCount = 0;
   always @(posedge clk) begin
      if (data_valid && data_ready) handshakeCount = handshakeCount + 1;
   end

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compareCount = compareCount + 1;
      if (observed !== expected) begin
         mismatchCount = mismatchCount + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle register write driven on the falling edge
   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      @(negedge clk);
      reg_wr    = 1'b1;
      reg_addr  = addr;
      reg_wdata = data;
      @(negedge clk);
      reg_wr    = 1'b0;
      reg_addr  = 2'd0;
      reg_wdata = 32'd0;
   endtask

   task automatic writeWord(input logic [31:0] lo, input logic [31:0] hi);
      applyStimulus(2'd0, lo);
      applyStimulus(2'd1, hi);
   endtask

   logic [63:0] ovWord;
   logic [63:0] togWords [3];
   logic [63:0] togExpect [5];
   logic        togReady [5];
   int          hsStart;

   // Main directed sequence
   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      reset      = 1'b0;
      reg_wr     = 1'b0;
      reg_addr   = 2'd0;
      reg_wdata  = 32'd0;
      data_ready = 1'b0;

      #1;
      checkOutput("reset_status", {32'd0, status}, 64'd0);
      checkOutput("reset_valid", {63'd0, data_valid}, 64'd0);
      checkOutput("reset_busy_done", {62'd0, busy, done}, 64'd0);
      checkOutput("reset_data", data_out, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Two-word stream at full throughput
      writeWord(32'h11111111, 32'h22222222);
      writeWord(32'h33333333, 32'h44444444);
      checkOutput("two_status_pre", {32'd0, status}, 64'h2);
      data_ready = 1'b1;
      applyStimulus(2'd2, 32'h1);
      checkOutput("two_beat0_valid", {63'd0, data_valid}, 64'd1);
      checkOutput("two_beat0_data", data_out, 64'h2222222211111111);
      checkOutput("two_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      checkOutput("two_beat1_valid", {63'd0, data_valid}, 64'd1);
      checkOutput("two_beat1_data", data_out, 64'h4444444433333333);
      @(negedge clk);
      checkOutput("two_done_pulse", {63'd0, done}, 64'd1);
      checkOutput("two_valid_off", {63'd0, data_valid}, 64'd0);
      checkOutput("two_status_done", {32'd0, status}, 64'h202);
      @(negedge clk);
      checkOutput("two_done_gone", {63'd0, done}, 64'd0);
      checkOutput("two_status_idle", {32'd0, status}, 64'h2);

      // Asynchronous reset while streaming
      data_ready = 1'b0;
      applyStimulus(2'd2, 32'h1);
      checkOutput("rst_mid_valid_pre", {63'd0, data_valid}, 64'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_mid_valid", {63'd0, data_valid}, 64'd0);
      checkOutput("rst_mid_status", {32'd0, status}, 64'd0);
      checkOutput("rst_mid_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_after_status", {32'd0, status}, 64'd0);

      // Fill to depth, then overflow with a ninth word
      for (int i = 0; i < 8; i++) writeWord(32'h50000000 + i, 32'hA0000000 + i);
      checkOutput("fill_status", {32'd0, status}, 64'h8);
      applyStimulus(2'd1, 32'hDEADBEEF);
      checkOutput("ovf_status", {32'd0, status}, 64'h808);
      hsStart    = handshakeCount;
      data_ready = 1'b1;
      applyStimulus(2'd2, 32'h1);
      for (int i = 0; i < 8; i++) begin
         ovWord = {32'hA0000000 + i, 32'h50000000 + i};
         checkOutput($sformatf("ovf_valid%0d", i), {63'd0, data_valid}, 64'd1);
         checkOutput($sformatf("ovf_beat%0d", i), data_out, ovWord);
         @(negedge clk);
      end
      checkOutput("ovf_no_ninth", {63'd0, data_valid}, 64'd0);
      checkOutput("ovf_done", {63'd0, done}, 64'd1);
      checkOutput("ovf_handshakes", 64'(handshakeCount - hsStart), 64'd8);

      // Back-pressure: ready pattern 1,0,0,1,1 over three words
      data_ready = 1'b0;
      applyStimulus(2'd2, 32'hA);
      checkOutput("tog_cleared", {32'd0, status}, 64'd0);
      togWords[0] = 64'hB0000000_C0000000;
      togWords[1] = 64'hB0000001_C0000001;
      togWords[2] = 64'hB0000002_C0000002;
      for (int i = 0; i < 3; i++) writeWord(togWords[i][31:0], togWords[i][63:32]);
      togReady[0]  = 1'b1; togExpect[0] = togWords[0];
      togReady[1]  = 1'b0; togExpect[1] = togWords[1];
      togReady[2]  = 1'b0; togExpect[2] = togWords[1];
      togReady[3]  = 1'b1; togExpect[3] = togWords[1];
      togReady[4]  = 1'b1; togExpect[4] = togWords[2];
      hsStart = handshakeCount;
      applyStimulus(2'd2, 32'h1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("tog_valid%0d", i), {63'd0, data_valid}, 64'd1);
         checkOutput($sformatf("tog_data%0d", i), data_out, togExpect[i]);
         data_ready = togReady[i];
         @(negedge clk);
      end
      checkOutput("tog_done", {63'd0, done}, 64'd1);
      checkOutput("tog_handshakes", 64'(handshakeCount - hsStart), 64'd3);

      // Start on an empty buffer is ignored
      applyStimulus(2'd2, 32'hA);
      data_ready = 1'b1;
      applyStimulus(2'd2, 32'h1);
      checkOutput("empty_valid", {63'd0, data_valid}, 64'd0);
      checkOutput("empty_status", {32'd0, status}, 64'd0);

      // Data write during a stream flags write_err and changes nothing
      data_ready = 1'b0;
      writeWord(32'h0000AAAA, 32'h0000BBBB);
      applyStimulus(2'd2, 32'h1);
      applyStimulus(2'd1, 32'h99999999);
      checkOutput("werr_status", {32'd0, status}, 64'h501);
      checkOutput("werr_data_held", data_out, 64'h0000BBBB_0000AAAA);
      data_ready = 1'b1;
      @(negedge clk);
      checkOutput("werr_done", {63'd0, done}, 64'd1);
      applyStimulus(2'd2, 32'h8);
      checkOutput("werr_flag_clear", {32'd0, status}, 64'h1);
      data_ready = 1'b0;
      applyStimulus(2'd2, 32'h1);
      checkOutput("replay_data", data_out, 64'h0000BBBB_0000AAAA);
      data_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);

`ifdef NPU_LOADER_REPEAT_EN
      // Looping playback continues until cleared
      applyStimulus(2'd2, 32'hA);
      writeWord(32'h0000000A, 32'hAAAAAAAA);
      writeWord(32'h0000000B, 32'hBBBBBBBB);
      applyStimulus(2'd2, 32'h5);
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("rep_data%0d", i), data_out,
                     (i % 2 == 0) ? 64'hAAAAAAAA_0000000A : 64'hBBBBBBBB_0000000B);
         checkOutput($sformatf("rep_nodone%0d", i), {62'd0, data_valid, done}, 64'h2);
         @(negedge clk);
      end
      applyStimulus(2'd2, 32'h2);
      checkOutput("rep_clear_valid", {63'd0, data_valid}, 64'd0);
      checkOutput("rep_clear_status", {32'd0, status}, 64'd0);
      checkOutput("rep_clear_done", {63'd0, done}, 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
